seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; legal values 4..32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 opcode  input  4  operation select.
REQ-009 out_valid  output  1  result on x/y/zero/err is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 x  output  WIDTH  primary result, registered.
REQ-012 y  output  WIDTH  secondary result (carry, borrow or high product), registered.
REQ-013 zero  output  1  high when x and y are both zero; qualified by out_valid.
REQ-014 err  output  1  high for a reserved or disabled opcode; qualified by out_valid.
REQ-015 busy  output  1  high while a multicycle multiply is in progress.

Function
REQ-016 The FSM SHALL have three states:
- IDLE: no result held.
- MUL: multiply in progress.
- DONE: result held.
REQ-017 in_ready SHALL be high in IDLE, and in DONE when out_ready is high; it SHALL be low in MUL.
REQ-018 An operation is accepted on an edge where in_valid and in_ready are both high.
- a, b and opcode are captured on that edge.
- Later changes to a, b or opcode SHALL have no effect on the accepted operation.
REQ-019 Single-cycle opcodes SHALL move the FSM to DONE on the accept edge, so out_valid is high in the following cycle (latency 1).
REQ-020 Opcode map (unlisted y = 0; unlisted x bits above bit 0 = 0):
- 0000: x[0] = OR-reduce(a).
- 0001: x[0] = AND-reduce(a).
- 0010: x[0] = XOR-reduce(a).
- 0011: x = a AND b.
- 0100: x = a OR b.
- 0101: x = a XOR b.
- 0110: x[0] = (a > b).
- 0111: x[0] = (a < b).
- 1000: reserved; x = 0, err = 1.
- 1001: x[0] = (a == b).
- 1010: x = (a + b) mod 2^WIDTH; y[0] = carry out.
- 1011: x = (a - b) mod 2^WIDTH; y[0] = borrow (a < b).
- 1100: {y,x} = a * b, unsigned, 2*WIDTH bits.
- 1101: x = a >> b, logical.
- 1110: x = a << b, logical.
- 1111: x = NOT a.
REQ-021 For opcodes 1101 and 1110, a shift amount b >= WIDTH SHALL give x = 0.
REQ-022 Opcode 1100 SHALL use a shift-add multiplier.
- FSM enters MUL on the accept edge and stays there exactly WIDTH cycles.
- FSM then enters DONE; out_valid rises WIDTH+1 cycles after the accept edge.
- busy is high exactly while in MUL.
REQ-023 In DONE with out_ready low, x, y, zero, err and out_valid SHALL hold stable.
REQ-024 In DONE with out_ready high:
- If a new operation is accepted on the same edge, the FSM follows REQ-019/REQ-022 (back-to-back, no bubble).
- Otherwise the FSM returns to IDLE and out_valid falls.
REQ-025 x, y, zero and err SHALL keep their last values when out_valid is low; they are don't-care for the consumer.

Reset
REQ-026 While rst_n is low:
- FSM is in IDLE.
- out_valid, busy, x, y, zero, err and the multiply counter/accumulator are all 0.
- in_ready is 1.
REQ-027 Reset asserted mid-multiply or in DONE SHALL discard the operation; no result is delivered.
REQ-028 On the first rising edge after rst_n deasserts, the block SHALL be able to accept an operation.

Configuration
REQ-029 Macro SEQ_ALU_MUL_EN defined: opcode 1100 SHALL behave per REQ-020/REQ-022.
REQ-030 Macro SEQ_ALU_MUL_EN undefined:
- No multiplier logic and no MUL state are built.
- Opcode 1100 completes in 1 cycle with x = y = 0 and err = 1.
- busy is tied to 0.

Verification (WIDTH=4)
REQ-031 Opcode 1010, a=1100, b=1010 -> one cycle after accept: out_valid=1, x=0110, y=0001, err=0.
REQ-032 Opcode 1011, a=0101, b=0110 -> x=1111, y=0001; then opcode 1000 -> x=0000, y=0000, err=1, zero=1.
REQ-033 Opcode 1100, a=1100, b=1010, macro defined:
- busy high for 4 cycles and in_ready low throughout.
- out_valid rises 5 cycles after accept with y=0111, x=1000.
- With the macro undefined: latency 1, x=y=0, err=1.
REQ-034 Backpressure and back-to-back:
- Opcode 0011 (a=1100, b=1010) with out_ready=0 for 3 cycles -> x=1000 held stable, in_ready=0.
- Then out_ready=1 with in_valid high and opcode 1111 -> next cycle out_valid=1, x=0011, no idle cycle.
REQ-035 rst_n driven low 2 cycles into a 1100 operation -> out_valid=0, busy=0, x=y=0, in_ready=1 immediately; no stale result after release.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready handshakes on both sides.
// Single-cycle opcodes deliver a result one cycle after accept. Opcode 1100
// is a WIDTH-cycle shift-add multiply when SEQ_ALU_MUL_EN is defined;
// otherwise it completes in one cycle with err=1 and no multiplier is built.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             err,
  output logic             busy
);

  localparam logic [3:0]     OP_MUL = 4'b1100;
  localparam logic [WIDTH:0] WLIM   = (WIDTH+1)'(WIDTH);

`ifdef SEQ_ALU_MUL_EN
  localparam int unsigned CW = $clog2(WIDTH);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd2} state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic             zero_q, err_q;

  logic [WIDTH-1:0] res_x, res_y;
  logic             res_err, res_zero;
  logic [WIDTH:0]   sum;
  logic             shift_big;
  logic             accept;

`ifdef SEQ_ALU_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_step;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               mul_last;
`endif

  assign sum       = {1'b0, a} + {1'b0, b};
  assign shift_big = ({1'b0, b} >= WLIM);

  // Single-cycle result for the opcode presented this cycle.
  always_comb begin
    res_x   = '0;
    res_y   = '0;
    res_err = 1'b0;
    case (opcode)
      4'b0000: res_x[0] = |a;
      4'b0001: res_x[0] = &a;
      4'b0010: res_x[0] = ^a;
      4'b0011: res_x    = a & b;
      4'b0100: res_x    = a | b;
      4'b0101: res_x    = a ^ b;
      4'b0110: res_x[0] = (a > b);
      4'b0111: res_x[0] = (a < b);
      4'b1000: res_err  = 1'b1;
      4'b1001: res_x[0] = (a == b);
      4'b1010: begin
        res_x    = sum[WIDTH-1:0];
        res_y[0] = sum[WIDTH];
      end
      4'b1011: begin
        res_x    = a - b;
        res_y[0] = (a < b);
      end
`ifdef SEQ_ALU_MUL_EN
      4'b1100: res_err = 1'b0;
`else
      4'b1100: res_err = 1'b1;
`endif
      4'b1101: res_x = shift_big ? '0 : (a >> b);
      4'b1110: res_x = shift_big ? '0 : (a << b);
      4'b1111: res_x = ~a;
    endcase
    res_zero = (res_x == '0) && (res_y == '0);
  end

`ifdef SEQ_ALU_MUL_EN
  // One shift-add partial product per MUL cycle.
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_last = (cnt_q == CW'(WIDTH-1));
  end
`endif

  assign accept = in_valid && in_ready;

  // Control FSM plus result and multiplier registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else if (accept) begin
      // Launch path shared by IDLE and the back-to-back DONE case.
`ifdef SEQ_ALU_MUL_EN
      if (opcode == OP_MUL) begin
        state_q  <= ST_MUL;
        mcand_q  <= {{WIDTH{1'b0}}, a};
        mplier_q <= b;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else begin
`else
      begin
`endif
        state_q <= ST_DONE;
        x_q     <= res_x;
        y_q     <= res_y;
        zero_q  <= res_zero;
        err_q   <= res_err;
      end
    end else begin
      case (state_q)
`ifdef SEQ_ALU_MUL_EN
        ST_MUL: begin
          acc_q    <= acc_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (mul_last) begin
            state_q <= ST_DONE;
            x_q     <= acc_step[WIDTH-1:0];
            y_q     <= acc_step[2*WIDTH-1:WIDTH];
            zero_q  <= (acc_step == '0);
            err_q   <= 1'b0;
          end
        end
`endif
        ST_DONE: if (out_ready) state_q <= ST_IDLE;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = (state_q == ST_DONE);
`ifdef SEQ_ALU_MUL_EN
  assign busy      = (state_q == ST_MUL);
`else
  assign busy      = 1'b0;
`endif
  assign x         = x_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule
